hangman_game: RTL and testbench
===============================

# hangman_game

Single-player Hangman game engine for module `hangman`. It accepts one ASCII letter guess per clock, tracks which letters have been guessed, and counts wrong guesses against a fixed secret word. It reports play, win or lose status. It is a self-contained leaf block: a host or testbench drives `letter` and reads `wrong_guesses` and `game_output`.

## Interface
- `WORD`, default `"salt"`: secret word, `WORD_LEN` packed 8-bit ASCII chars, lowercase a–z only, MSB char first.
- `WORD_LEN`, default 4: number of characters in `WORD`, 1..8.
- `MAX_WRONG`, default 6: wrong-guess count that ends the game as LOSE, 1..7.
- `clk`  input  1  single clock; all state changes on its rising edge.
- `rst`  input  1  synchronous, active-low reset.
- `letter`  input  7  ASCII code of the current guess; sampled every rising edge.
- `wrong_guesses`  output  3  number of distinct wrong letters guessed this game; registered.
- `game_output`  output  2  game status: 0 = PLAY, 1 = LOSE, 2 = WIN, 3 = unused (never driven); registered.

## Operation
- Decode `letter`:
  - 'a'–'z' maps to index 0–25.
  - 'A'–'Z' is folded to the same index.
  - Any other code (space, digits, punctuation) is not a guess and is ignored.
- State:
  - 26-bit `guessed` mask.
  - 3-bit wrong counter.
  - 2-bit status register.
- In PLAY, for a valid letter whose `guessed` bit is clear:
  - Set the `guessed` bit.
  - If the letter does not occur in `WORD`, increment the wrong counter.
- A letter already in `guessed` (right or wrong) is ignored. It changes neither the count nor the status, so holding a letter for several cycles counts once.
- Win condition: every character of `WORD` has its `guessed` bit set. Evaluate it on the updated mask, so the guess that completes the word wins in the same update.
- Lose condition: the updated wrong count equals `MAX_WRONG`.
- Win and lose cannot both occur in one update, because a single guess is either right or wrong.
- WIN and LOSE are terminal:
  - All further guesses are ignored.
  - Outputs hold until reset.
- Reset (`rst` = 0 at a rising edge):
  - Clear `guessed`.
  - `wrong_guesses` = 0, `game_output` = 0 (PLAY).
  - Reset has priority over any guess in the same cycle and is valid at any point mid-game.

## Timing
- Outputs are registered. A guess sampled at edge N is reflected on the outputs immediately after edge N, and is readable before edge N+1.
- No handshake and no ready signal; one guess can be evaluated every cycle.
- First guess is accepted on the first edge with `rst` = 1.
- Combinational path: decode, then 26-entry mask lookup, then word compare (`WORD_LEN` × 5-bit comparators), then counter increment. This must close in one cycle.

## Structure
- Package `hangman_pkg`:
  - Status constants `ST_PLAY` = 0, `ST_LOSE` = 1, `ST_WIN` = 2.
  - ASCII range constants.
- Sub-module `hangman_letter_decode`:
  - Input: 7-bit ASCII.
  - Outputs: 5-bit index, `valid`.
  - Purely combinational; handles case folding.
- Top level:
  - Mask register, counter and status register.
  - Word-membership logic, generated per `WORD` character.

## Test plan
- Reset with default word, then guess q, w, q, z, v (one per cycle) → wrong_guesses 1,2,2,3,4; game_output PLAY throughout (repeat q not counted).
- Reset, then guess p, a, s, s, q, l, z, t, a, z, z → status WIN after t with wrong_guesses = 3. Later guesses change nothing.
- Reset, then guess l, a, s, q, p, z, t, u, z → WIN after t, wrong_guesses = 3; u and z ignored afterwards.
- Reset, then guess b, c, d, e, f, g → wrong_guesses reaches 6 and game_output = LOSE on the g update. A following 's' is ignored.
- Guess ' ', '5', 'S', 'A' → space and '5' ignored; 'S' and 'A' counted as correct. A later 's' is a repeat with no effect.
- Mid-game reset after 3 wrong guesses, with a letter held on `letter` during reset → outputs 0/PLAY, mask cleared, held letter not applied. Repeat scenario 1 and require identical results.

Source files
------------

// File: rtl/hangman_pkg.sv
// Shared constants and types for the hangman game engine.
//   Status encoding reported on game_output, ASCII range limits used by the
//   letter decoder, and common widths.
package hangman_pkg;

    localparam int unsigned NUM_LETTERS  = 26;
    localparam int unsigned LETTER_IDX_W = 5;
    localparam int unsigned CNT_W        = 3;
    localparam int unsigned STATUS_W     = 2;
    localparam int unsigned ASCII_W      = 7;

    localparam logic [ASCII_W-1:0] ASCII_LOWER_A = 7'h61;
    localparam logic [ASCII_W-1:0] ASCII_LOWER_Z = 7'h7A;
    localparam logic [ASCII_W-1:0] ASCII_UPPER_A = 7'h41;
    localparam logic [ASCII_W-1:0] ASCII_UPPER_Z = 7'h5A;

    // Game status; value 3 is never produced.
    typedef enum logic [STATUS_W-1:0] {
        ST_PLAY = 2'd0,
        ST_LOSE = 2'd1,
        ST_WIN  = 2'd2
    } status_t;

endpackage

// File: rtl/hangman_letter_decode.sv
// Combinational ASCII letter decoder with case folding.
//   ascii : 7-bit ASCII code of the guess
//   index : 0..25 letter index ('a'/'A' = 0), meaningful only when valid
//   valid : high for 'a'..'z' or 'A'..'Z'
module hangman_letter_decode
    import hangman_pkg::*;
(
    input  logic [ASCII_W-1:0]      ascii,
    output logic [LETTER_IDX_W-1:0] index,
    output logic                    valid
);

    logic is_lower;
    logic is_upper;

    assign is_lower = (ascii >= ASCII_LOWER_A) && (ascii <= ASCII_LOWER_Z);
    assign is_upper = (ascii >= ASCII_UPPER_A) && (ascii <= ASCII_UPPER_Z);
    assign valid    = is_lower || is_upper;

    // Fold both cases onto the same index; non-letters yield index 0.
    always_comb begin
        index = '0;
        if (is_lower) begin
            index = LETTER_IDX_W'(ascii - ASCII_LOWER_A);
        end else if (is_upper) begin
            index = LETTER_IDX_W'(ascii - ASCII_UPPER_A);
        end
    end

endmodule

// File: rtl/hangman_game.sv
// Single-player hangman engine: one letter guess per clock against a fixed word.
//   clk           : clock, all state changes on rising edge
//   rst           : synchronous active-low reset
//   letter        : ASCII guess, sampled every rising edge
//   wrong_guesses : distinct wrong letters this game (registered)
//   game_output   : 0 = PLAY, 1 = LOSE, 2 = WIN (registered)
module hangman_game
    import hangman_pkg::*;
#(
    parameter int unsigned              WORD_LEN  = 4,
    parameter logic [8*WORD_LEN-1:0]    WORD      = "salt",
    parameter int unsigned              MAX_WRONG = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ASCII_W-1:0]  letter,
    output logic [CNT_W-1:0]    wrong_guesses,
    output logic [STATUS_W-1:0] game_output
);

    localparam logic [7:0] CHAR_BASE = 8'({1'b0, ASCII_LOWER_A});

    logic [NUM_LETTERS-1:0]  guessed_q;
    logic [NUM_LETTERS-1:0]  guessed_upd;
    logic [CNT_W-1:0]        wrong_q;
    logic [CNT_W-1:0]        wrong_d;
    status_t                 status_q;
    status_t                 status_d;

    logic [LETTER_IDX_W-1:0] idx;
    logic                    idx_valid;
    logic                    guess_new;
    logic                    in_word;
    logic [WORD_LEN-1:0]     char_hit;
    logic [WORD_LEN-1:0]     char_done;

    hangman_letter_decode u_decode (
        .ascii (letter),
        .index (idx),
        .valid (idx_valid)
    );

    // A guess only counts while playing and the first time a letter is seen.
    assign guess_new   = idx_valid && !guessed_q[idx] && (status_q == ST_PLAY);
    assign guessed_upd = guessed_q
                       | (guess_new ? (NUM_LETTERS'(1) << idx) : '0);

    // Per-character membership and completion against the updated mask.
    for (genvar i = 0; i < WORD_LEN; i++) begin : g_char
        localparam logic [7:0]              CH = WORD[8*(WORD_LEN-1-i) +: 8];
        localparam logic [LETTER_IDX_W-1:0] CI = LETTER_IDX_W'(CH - CHAR_BASE);
        assign char_hit[i]  = (idx == CI);
        assign char_done[i] = guessed_upd[CI];
    end

    assign in_word = |char_hit;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            guessed_q <= '0;
            wrong_q   <= '0;
            status_q  <= ST_PLAY;
        end else begin
            guessed_q <= guessed_upd;
            wrong_q   <= wrong_d;
            status_q  <= status_d;
        end
    end

    // Next-state: score a fresh guess; WIN/LOSE are absorbing.
    always_comb begin
        wrong_d  = wrong_q;
        status_d = status_q;
        case (status_q)
            ST_PLAY: begin
                if (guess_new) begin
                    if (!in_word) begin
                        wrong_d = wrong_q + CNT_W'(1);
                    end
                    if (&char_done) begin
                        status_d = ST_WIN;
                    end else if (wrong_d == CNT_W'(MAX_WRONG)) begin
                        status_d = ST_LOSE;
                    end
                end
            end
            default: begin
                status_d = status_q;
            end
        endcase
    end

    assign wrong_guesses = wrong_q;
    assign game_output   = status_q;

endmodule

// File: tb/tb_hangman_game.sv
// Self-checking bench for hangman_game: directed scenarios plus randomized
// games compared against a letter-set reference model.
module tb_hangman_game;

    localparam int MAX_WRONG = 6;

    logic       clk;
    logic       rst;
    logic [6:0] letter;
    logic [2:0] wrong_guesses;
    logic [1:0] game_output;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    string   m_word = "salt";
    bit      m_seen [26];
    int      m_wrong;
    int      m_status;

    hangman_game #(
        .WORD_LEN  (4),
        .WORD      ("salt"),
        .MAX_WRONG (MAX_WRONG)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .letter        (letter),
        .wrong_guesses (wrong_guesses),
        .game_output   (game_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        foreach (m_seen[i]) m_seen[i] = 1'b0;
        m_wrong  = 0;
        m_status = 0;
    endfunction

    function automatic void model_step(input int c);
        int  k;
        bit  found;
        bit  all_seen;
        if (c >= 97 && c <= 122)      k = c - 97;
        else if (c >= 65 && c <= 90)  k = c - 65;
        else return;
        if (m_status != 0) return;
        if (m_seen[k]) return;
        m_seen[k] = 1'b1;
        found    = 1'b0;
        all_seen = 1'b1;
        for (int i = 0; i < m_word.len(); i++) begin
            if (int'(m_word[i]) - 97 == k) found = 1'b1;
            if (!m_seen[int'(m_word[i]) - 97]) all_seen = 1'b0;
        end
        if (!found) m_wrong++;
        if (all_seen)                  m_status = 2;
        else if (m_wrong == MAX_WRONG) m_status = 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        model_reset();
    endtask

    task automatic step(input byte c);
        letter = 7'(c);
        tick();
        model_step(int'(c));
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        letter = 7'h71;
        tick();
        tick();
        model_reset();
        checks++;
        if (wrong_guesses !== 3'd0 || game_output !== 2'd0) begin
            failures++;
            $display("FAIL reset: wrong=%0d status=%0d, required 0/0", wrong_guesses, game_output);
        end
        letter = 7'h20;
        rst    = 1'b1;
    endtask

    task automatic test_wrong_count();
        string g = "qwqzv";
        int    exp_w [5] = '{1, 2, 2, 3, 4};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(g[i]);
            checks++;
            if (wrong_guesses !== 3'(exp_w[i]) || game_output !== 2'd0) begin
                failures++;
                $display("FAIL wrong_count[%0d] '%c': wrong=%0d status=%0d, required %0d/0",
                         i, g[i], wrong_guesses, game_output, exp_w[i]);
            end
        end
    endtask

    task automatic test_win_mixed();
        string g = "paassqlztazz";
        do_reset();
        g = "passqlztazz";
        for (int i = 0; i < g.len(); i++) begin
            step(g[i]);
            checks++;
            if (wrong_guesses !== 3'(m_wrong) || game_output !== 2'(m_status)) begin
                failures++;
                $display("FAIL win_mixed[%0d] '%c': wrong=%0d status=%0d, required %0d/%0d",
                         i, g[i], wrong_guesses, game_output, m_wrong, m_status);
            end
            if (i == 7) begin
                checks++;
                if (game_output !== 2'd2 || wrong_guesses !== 3'd3) begin
                    failures++;
                    $display("FAIL win_mixed_at_t: wrong=%0d status=%0d, required 3/2",
                             wrong_guesses, game_output);
                end
            end
        end
        checks++;
        if (game_output !== 2'd2 || wrong_guesses !== 3'd3) begin
            failures++;
            $display("FAIL win_mixed_final: wrong=%0d status=%0d, required 3/2", wrong_guesses, game_output);
        end
    endtask

    task automatic test_win_late();
        string g = "lasqpztuz";
        do_reset();
        for (int i = 0; i < g.len(); i++) begin
            step(g[i]);
            checks++;
            if (wrong_guesses !== 3'(m_wrong) || game_output !== 2'(m_status)) begin
                failures++;
                $display("FAIL win_late[%0d] '%c': wrong=%0d status=%0d, required %0d/%0d",
                         i, g[i], wrong_guesses, game_output, m_wrong, m_status);
            end
        end
        checks++;
        if (game_output !== 2'd2 || wrong_guesses !== 3'd3) begin
            failures++;
            $display("FAIL win_late_final: wrong=%0d status=%0d, required 3/2", wrong_guesses, game_output);
        end
    endtask

    task automatic test_lose();
        string g = "bcdefg";
        do_reset();
        for (int i = 0; i < g.len(); i++) begin
            step(g[i]);
            checks++;
            if (wrong_guesses !== 3'(i + 1) || game_output !== ((i == 5) ? 2'd1 : 2'd0)) begin
                failures++;
                $display("FAIL lose[%0d] '%c': wrong=%0d status=%0d, required %0d/%0d",
                         i, g[i], wrong_guesses, game_output, i + 1, (i == 5) ? 1 : 0);
            end
        end
        step("s");
        step("h");
        checks++;
        if (wrong_guesses !== 3'd6 || game_output !== 2'd1) begin
            failures++;
            $display("FAIL lose_hold: wrong=%0d status=%0d, required 6/1", wrong_guesses, game_output);
        end
    endtask

    task automatic test_case_fold();
        do_reset();
        step(" ");
        step("5");
        step("S");
        step("A");
        step("s");
        checks++;
        if (wrong_guesses !== 3'd0 || game_output !== 2'd0) begin
            failures++;
            $display("FAIL case_fold: wrong=%0d status=%0d, required 0/0", wrong_guesses, game_output);
        end
        // Only l and t remain; finishing with uppercase proves S/A were recorded.
        step("L");
        step("T");
        checks++;
        if (wrong_guesses !== 3'd0 || game_output !== 2'd2) begin
            failures++;
            $display("FAIL case_fold_win: wrong=%0d status=%0d, required 0/2", wrong_guesses, game_output);
        end
    endtask

    task automatic test_mid_reset();
        string g = "qwqzv";
        int    exp_w [5] = '{1, 2, 2, 3, 4};
        do_reset();
        step("b");
        step("c");
        step("d");
        checks++;
        if (wrong_guesses !== 3'd3) begin
            failures++;
            $display("FAIL pre_reset: wrong=%0d, required 3", wrong_guesses);
        end
        letter = 7'h65;
        rst    = 1'b0;
        tick();
        tick();
        model_reset();
        checks++;
        if (wrong_guesses !== 3'd0 || game_output !== 2'd0) begin
            failures++;
            $display("FAIL mid_reset: wrong=%0d status=%0d, required 0/0", wrong_guesses, game_output);
        end
        letter = 7'h20;
        rst    = 1'b1;
        step("b");
        checks++;
        if (wrong_guesses !== 3'd1) begin
            failures++;
            $display("FAIL mask_cleared: wrong=%0d, required 1", wrong_guesses);
        end
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(g[i]);
            checks++;
            if (wrong_guesses !== 3'(exp_w[i]) || game_output !== 2'd0) begin
                failures++;
                $display("FAIL rerun[%0d] '%c': wrong=%0d status=%0d, required %0d/0",
                         i, g[i], wrong_guesses, game_output, exp_w[i]);
            end
        end
    endtask

    task automatic test_random();
        byte c;
        byte prev;
        int  r;
        prev = "a";
        for (int game = 0; game < 12; game++) begin
            do_reset();
            for (int n = 0; n < 30; n++) begin
                r = int'($urandom_range(0, 19));
                if (r < 8)        c = byte'(97 + $urandom_range(0, 25));
                else if (r < 12)  c = m_word[$urandom_range(0, 3)];
                else if (r < 14)  c = byte'(65 + $urandom_range(0, 25));
                else if (r < 16)  c = byte'($urandom_range(0, 127));
                else if (r < 19)  c = prev;
                else              c = " ";
                if ($urandom_range(0, 39) == 0) begin
                    letter = 7'(c);
                    do_reset();
                end else begin
                    step(c);
                end
                prev = c;
                checks++;
                if (wrong_guesses !== 3'(m_wrong) || game_output !== 2'(m_status)) begin
                    failures++;
                    $display("FAIL random g%0d n%0d code=%0d: wrong=%0d status=%0d, required %0d/%0d",
                             game, n, c, wrong_guesses, game_output, m_wrong, m_status);
                end
            end
        end
    endtask

    initial begin
        rst    = 1'b0;
        letter = 7'h20;
        model_reset();
        test_reset();
        test_wrong_count();
        test_win_mixed();
        test_win_late();
        test_lose();
        test_case_fold();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
